// File: rtl/cr_kme_fifo_beat_unpacker.sv
// Drains 83-bit KME FIFO entries and splits each 64-bit payload into one or two
// 32-bit beats on a registered valid/ready port, with framing checks and a frame counter.
module cr_kme_fifo_beat_unpacker #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [82:0]      fifo_out,
  input  logic             fifo_out_valid,
  output logic             fifo_out_ack,
  output logic [31:0]      beat_data,
  output logic [1:0]       beat_bytes,
  output logic             beat_sot,
  output logic             beat_eot,
  output logic [7:0]       beat_tid,
  output logic             beat_valid,
  input  logic             beat_ready,
  output logic             proto_err,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam logic [0:0] HALF_LO = 1'b0;
  localparam logic [0:0] HALF_HI = 1'b1;

  logic        in_sot;
  logic        in_eot;
  logic [7:0]  in_tid;
  logic [2:0]  in_nbytes_m1;
  logic [63:0] in_data;
  logic        unused_bits;

  assign in_sot       = fifo_out[82];
  assign in_eot       = fifo_out[81];
  assign in_tid       = fifo_out[80:73];
  assign in_nbytes_m1 = fifo_out[66:64];
  assign in_data      = fifo_out[63:0];
  assign unused_bits  = ^fifo_out[72:67];

  logic [0:0]  half;
  logic [0:0]  half_nxt;
  logic        in_frame;
  logic        in_frame_nxt;
  logic        load_ok;
  logic        one_beat;
  logic        orphan;
  logic        load_lo;
  logic        load_hi;
  logic        nested;

  logic [31:0] beat_data_nxt;
  logic [1:0]  beat_bytes_nxt;
  logic        beat_sot_nxt;
  logic        beat_eot_nxt;
  logic [7:0]  beat_tid_nxt;
  logic        beat_valid_nxt;

  assign load_ok  = !beat_valid || beat_ready;
  assign one_beat = in_eot && !in_nbytes_m1[2];

  // An orphan entry is discarded even under backpressure so it cannot wedge the FIFO.
  assign orphan  = (half == HALF_LO) && fifo_out_valid && !in_sot && !in_frame;
  assign load_lo = (half == HALF_LO) && fifo_out_valid && !orphan && load_ok;
  assign load_hi = (half == HALF_HI) && fifo_out_valid && load_ok;
  assign nested  = load_lo && in_sot && in_frame;

  // The entry is popped only once its last beat loads, so a reset mid-entry replays it.
  assign fifo_out_ack = !rst && (orphan || (load_lo && one_beat) || load_hi);

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that leaves
    // one unassigned would infer a latch.
    half_nxt       = half;
    in_frame_nxt   = in_frame;
    beat_data_nxt  = beat_data;
    beat_bytes_nxt = beat_bytes;
    beat_sot_nxt   = beat_sot;
    beat_eot_nxt   = beat_eot;
    beat_tid_nxt   = beat_tid;
    beat_valid_nxt = beat_valid;

    if (load_lo) begin
      beat_data_nxt  = in_data[31:0];
      beat_sot_nxt   = in_sot;
      beat_tid_nxt   = in_tid;
      beat_valid_nxt = 1'b1;
      if (one_beat) begin
        beat_eot_nxt   = 1'b1;
        beat_bytes_nxt = in_nbytes_m1[1:0];
        in_frame_nxt   = 1'b0;
      end else begin
        beat_eot_nxt   = 1'b0;
        beat_bytes_nxt = 2'd3;
        half_nxt       = HALF_HI;
        if (in_sot) in_frame_nxt = 1'b1;
      end
    end else if (load_hi) begin
      beat_data_nxt  = in_data[63:32];
      beat_sot_nxt   = 1'b0;
      beat_eot_nxt   = in_eot;
      // A two-beat eot entry has nbytes_m1 >= 4, so nbytes_m1-4 is just its low two bits.
      beat_bytes_nxt = in_eot ? in_nbytes_m1[1:0] : 2'd3;
      beat_tid_nxt   = in_tid;
      beat_valid_nxt = 1'b1;
      half_nxt       = HALF_LO;
      if (in_eot) in_frame_nxt = 1'b0;
    end else if (beat_valid && beat_ready) begin
      beat_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      half       <= HALF_LO;
      in_frame   <= 1'b0;
      beat_data  <= '0;
      beat_bytes <= '0;
      beat_sot   <= 1'b0;
      beat_eot   <= 1'b0;
      beat_tid   <= '0;
      beat_valid <= 1'b0;
      proto_err  <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples
      // pre-edge values regardless of statement order.
      half       <= half_nxt;
      in_frame   <= in_frame_nxt;
      beat_data  <= beat_data_nxt;
      beat_bytes <= beat_bytes_nxt;
      beat_sot   <= beat_sot_nxt;
      beat_eot   <= beat_eot_nxt;
      beat_tid   <= beat_tid_nxt;
      beat_valid <= beat_valid_nxt;
      proto_err  <= orphan || nested;
      if (beat_valid && beat_ready && beat_eot) frame_cnt <= frame_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cr_kme_fifo_beat_unpacker.sv
// Scoreboard bench for cr_kme_fifo_beat_unpacker: a queue-backed FIFO model feeds
// entries, expected beats are queued at push time and compared on each handshake.
module tb_cr_kme_fifo_beat_unpacker;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  bytes;
    logic        sot;
    logic        eot;
    logic [7:0]  tid;
  } beat_t;

  logic        clk;
  logic        rst;
  logic [82:0] fifo_out;
  logic        fifo_out_valid;
  logic        fifo_out_ack;
  logic [31:0] beat_data;
  logic [1:0]  beat_bytes;
  logic        beat_sot;
  logic        beat_eot;
  logic [7:0]  beat_tid;
  logic        beat_valid;
  logic        beat_ready;
  logic        proto_err;
  logic [1:0]  frame_cnt;

  cr_kme_fifo_beat_unpacker #(.CNT_W(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .fifo_out       (fifo_out),
    .fifo_out_valid (fifo_out_valid),
    .fifo_out_ack   (fifo_out_ack),
    .beat_data      (beat_data),
    .beat_bytes     (beat_bytes),
    .beat_sot       (beat_sot),
    .beat_eot       (beat_eot),
    .beat_tid       (beat_tid),
    .beat_valid     (beat_valid),
    .beat_ready     (beat_ready),
    .proto_err      (proto_err),
    .frame_cnt      (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  logic [82:0] fifo_q[$];
  beat_t       exp_q[$];
  int          exp_cnt = 0;

  int first_beat, last_beat, n_beats, first_ack, last_ack, pe_cnt, pe_cyc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [82:0] mk(input bit sot, input bit eot, input logic [7:0] tid,
                                     input logic [2:0] nb, input logic [63:0] d);
    return {sot, eot, tid, 6'h15, nb, d};
  endfunction

  function automatic beat_t cur_beat();
    return {beat_data, beat_bytes, beat_sot, beat_eot, beat_tid};
  endfunction

  task automatic push_expect(input logic [82:0] e);
    beat_t       b;
    logic        eot;
    logic [2:0]  nb;
    logic [63:0] d;
    eot    = e[81];
    nb     = e[66:64];
    d      = e[63:0];
    b.data = d[31:0];
    b.sot  = e[82];
    b.tid  = e[80:73];
    if (eot && nb <= 3'd3) begin
      b.eot   = 1'b1;
      b.bytes = nb[1:0];
      exp_q.push_back(b);
    end else begin
      b.eot   = 1'b0;
      b.bytes = 2'd3;
      exp_q.push_back(b);
      b.data  = d[63:32];
      b.sot   = 1'b0;
      b.eot   = eot;
      b.bytes = eot ? 2'(nb - 3'd4) : 2'd3;
      exp_q.push_back(b);
    end
  endtask

  task automatic push_entry(input logic [82:0] e, input bit drop);
    fifo_q.push_back(e);
    if (!drop) push_expect(e);
  endtask

  // Runs from posedge+1 until the FIFO, scoreboard and output register are idle.
  task automatic run(input int stall_start, input int stall_len);
    int    cyc;
    int    idle;
    bit    ack_now;
    bit    in_stall;
    beat_t snap;
    beat_t e;
    cyc = 0; idle = 0;
    first_beat = -1; last_beat = -1; n_beats = 0;
    first_ack = -1; last_ack = -1; pe_cnt = 0; pe_cyc = -1;
    snap = '0;
    while (idle < 3 && cyc < 200) begin
      fifo_out_valid = (fifo_q.size() != 0);
      fifo_out       = fifo_out_valid ? fifo_q[0] : '0;
      in_stall       = (cyc >= stall_start) && (cyc < stall_start + stall_len);
      beat_ready     = !in_stall;
      #4;
      check("ack_gated", {63'd0, fifo_out_ack & ~fifo_out_valid}, 64'd0);
      if (fifo_out_ack) begin
        if (first_ack < 0) first_ack = cyc;
        last_ack = cyc;
      end
      if (proto_err) begin
        pe_cnt++;
        if (pe_cyc < 0) pe_cyc = cyc;
      end
      if (in_stall) begin
        check("stall_ack", {63'd0, fifo_out_ack}, 64'd0);
        if (cyc == stall_start) snap = cur_beat();
        else check("stall_hold", {20'd0, cur_beat()}, {20'd0, snap});
      end
      if (beat_valid && beat_ready) begin
        if (first_beat < 0) first_beat = cyc;
        last_beat = cyc;
        n_beats++;
        check("extra_beat", {63'd0, exp_q.size() != 0}, 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("beat", {20'd0, cur_beat()}, {20'd0, e});
          if (e.eot) exp_cnt++;
        end
      end
      ack_now = fifo_out_ack;
      idle = (fifo_q.size() == 0 && exp_q.size() == 0 && !beat_valid) ? idle + 1 : 0;
      @(posedge clk); #1;
      if (ack_now && fifo_q.size() != 0) void'(fifo_q.pop_front());
      cyc++;
    end
    check("timeout", {63'd0, idle >= 3}, 64'd1);
    check("fifo_drained", 64'(fifo_q.size()), 64'd0);
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    check("frame_cnt", {62'd0, frame_cnt}, {62'd0, 2'(exp_cnt)});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [82:0] e;
    rst            = 1'b1;
    beat_ready     = 1'b0;
    fifo_out       = mk(1'b0, 1'b0, 8'h99, 3'd0, 64'hdead_beef_0000_0001);
    fifo_out_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", {63'd0, fifo_out_ack}, 64'd0);
    check("rst_beat", {20'd0, cur_beat()}, 64'd0);
    check("rst_valid", {63'd0, beat_valid}, 64'd0);
    check("rst_perr_cnt", {61'd0, proto_err, frame_cnt}, 64'd0);
    fifo_out_valid = 1'b0;
    rst            = 1'b0;
    @(posedge clk); #1;

    // Single two-beat frame.
    push_entry(mk(1'b1, 1'b1, 8'h11, 3'd5, 64'h1122334455667788), 1'b0);
    run(-10, 0);
    check("t1_first_beat", 64'(first_beat), 64'd1);
    check("t1_ack_cyc", 64'(first_ack), 64'd1);
    check("t1_last_beat", 64'(last_beat), 64'd2);
    check("t1_frame_cnt", {62'd0, frame_cnt}, 64'd1);

    // Three-entry frame ending in a short eot entry.
    push_entry(mk(1'b1, 1'b0, 8'h22, 3'd0, 64'hA0A1A2A3_A4A5A6A7), 1'b0);
    push_entry(mk(1'b0, 1'b0, 8'h22, 3'd6, 64'hB0B1B2B3_B4B5B6B7), 1'b0);
    push_entry(mk(1'b0, 1'b1, 8'h22, 3'd2, 64'hC0C1C2C3_C4C5C6C7), 1'b0);
    run(-10, 0);
    check("t2_n_beats", 64'(n_beats), 64'd5);
    check("t2_first_beat", 64'(first_beat), 64'd1);
    check("t2_last_beat", 64'(last_beat), 64'd5);
    check("t2_last_ack", 64'(last_ack), 64'd4);

    // Backpressure for 4 cycles with the first beat of an entry held.
    push_entry(mk(1'b1, 1'b0, 8'h33, 3'd0, 64'h0123456789ABCDEF), 1'b0);
    push_entry(mk(1'b0, 1'b1, 8'h33, 3'd7, 64'hFEDCBA9876543210), 1'b0);
    run(1, 4);
    check("t3_n_beats", 64'(n_beats), 64'd4);
    check("t3_perr", 64'(pe_cnt), 64'd0);

    // Orphan entry while idle.
    push_entry(mk(1'b0, 1'b1, 8'h44, 3'd1, 64'h5555_5555_5555_5555), 1'b1);
    run(-10, 0);
    check("t4_ack_cyc", 64'(first_ack), 64'd0);
    check("t4_no_beat", 64'(n_beats), 64'd0);
    check("t4_perr_cnt", 64'(pe_cnt), 64'd1);
    check("t4_perr_cyc", 64'(pe_cyc), 64'd1);

    // Nested sot abandons the open frame.
    push_entry(mk(1'b1, 1'b0, 8'h55, 3'd0, 64'h1111_2222_3333_4444), 1'b0);
    push_entry(mk(1'b1, 1'b1, 8'h56, 3'd1, 64'h5555_6666_7777_8888), 1'b0);
    run(-10, 0);
    check("t5_n_beats", 64'(n_beats), 64'd3);
    check("t5_perr_cnt", 64'(pe_cnt), 64'd1);
    check("t5_perr_cyc", 64'(pe_cyc), 64'd3);

    // Five single-beat frames push the 2-bit counter across its wrap.
    for (int i = 0; i < 5; i++)
      push_entry(mk(1'b1, 1'b1, 8'(8'h60 + i), 3'(i % 4), {32'h0, $urandom}), 1'b0);
    run(-10, 0);
    check("t6_wrap_cnt", {62'd0, frame_cnt}, 64'd1);

    // Reset after the low half of a two-beat entry has loaded.
    e = mk(1'b1, 1'b0, 8'h77, 3'd0, 64'hCAFEF00D_12345678);
    fifo_q.push_back(e);
    fifo_out       = e;
    fifo_out_valid = 1'b1;
    beat_ready     = 1'b0;
    @(posedge clk); #1;
    check("t7_lo_loaded", {31'd0, beat_valid, beat_data}, {31'd0, 1'b1, 32'h12345678});
    rst        = 1'b1;
    beat_ready = 1'b1;
    #4;
    check("t7_ack_in_rst", {63'd0, fifo_out_ack}, 64'd0);
    @(posedge clk); #1;
    check("t7_rst_beat", {20'd0, cur_beat()}, 64'd0);
    check("t7_rst_flags", {61'd0, beat_valid, proto_err, frame_cnt != 2'd0}, 64'd0);
    rst     = 1'b0;
    exp_cnt = 0;
    push_expect(e);
    push_entry(mk(1'b0, 1'b1, 8'h77, 3'd4, 64'h0BADC0DE_00C0FFEE), 1'b0);
    run(-10, 0);
    check("t7_first_beat", 64'(first_beat), 64'd1);
    check("t7_n_beats", 64'(n_beats), 64'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
